// File: rtl/vector_logic_pkg.sv
// Shared types and constants for the vector logic sequencing blocks:
// controller state encodings, operation select codes and zero/one constants.
package vector_logic_pkg;

  localparam int DATA_SIZE_DEFAULT    = 64;
  localparam int CONTROL_SIZE_DEFAULT = 64;

  typedef logic [1:0] state_t;

  localparam state_t STATE_IDLE    = 2'b00;
  localparam state_t STATE_INPUT   = 2'b01;
  localparam state_t STATE_COMPUTE = 2'b10;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } logic_op_t;

  localparam logic [DATA_SIZE_DEFAULT-1:0]    ZERO_DATA    = {DATA_SIZE_DEFAULT{1'b0}};
  localparam logic [CONTROL_SIZE_DEFAULT-1:0] ZERO_CONTROL = {CONTROL_SIZE_DEFAULT{1'b0}};
  localparam logic [CONTROL_SIZE_DEFAULT-1:0] ONE_CONTROL  =
    {{(CONTROL_SIZE_DEFAULT-1){1'b0}}, 1'b1};

endpackage

// File: rtl/logic_operand_capture.sv
// A/B operand holding registers with first-capture-wins flags; both_captured
// reports that both operands will be held after the current cycle.
module logic_operand_capture
  import vector_logic_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 capture_en,
  input  logic                 clear,
  input  logic                 data_a_in_enable,
  input  logic                 data_b_in_enable,
  input  logic [DATA_SIZE-1:0] data_a_in,
  input  logic [DATA_SIZE-1:0] data_b_in,
  output logic [DATA_SIZE-1:0] operand_a,
  output logic [DATA_SIZE-1:0] operand_b,
  output logic                 both_captured
);

  logic                 flag_a_r;
  logic                 flag_b_r;
  logic [DATA_SIZE-1:0] operand_a_r;
  logic [DATA_SIZE-1:0] operand_b_r;
  logic                 take_a_s;
  logic                 take_b_s;

  // Capture decisions; an operand already held ignores further enables
  always_comb begin
    take_a_s = 1'b0;
    take_b_s = 1'b0;
    if (capture_en) begin
      take_a_s = data_a_in_enable & ~flag_a_r;
      take_b_s = data_b_in_enable & ~flag_b_r;
    end else begin
      take_a_s = 1'b0;
      take_b_s = 1'b0;
    end
  end

  // Holding registers and flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flag_a_r    <= 1'b0;
      flag_b_r    <= 1'b0;
      operand_a_r <= ZERO_DATA;
      operand_b_r <= ZERO_DATA;
    end else if (clear) begin
      flag_a_r <= 1'b0;
      flag_b_r <= 1'b0;
    end else begin
      if (take_a_s) begin
        flag_a_r    <= 1'b1;
        operand_a_r <= data_a_in;
      end
      if (take_b_s) begin
        flag_b_r    <= 1'b1;
        operand_b_r <= data_b_in;
      end
    end
  end

  // Look-ahead on the enables lets both-in-one-cycle reach COMPUTE next cycle
  always_comb begin
    if (capture_en) begin
      both_captured = (flag_a_r | take_a_s) & (flag_b_r | take_b_s);
    end else begin
      both_captured = 1'b0;
    end
  end

  assign operand_a = operand_a_r;
  assign operand_b = operand_b_r;

endmodule

// File: rtl/vector_xor_controller.sv
// Sequences element-wise logic operations over a vector of SIZE_IN pairs.
// Optional feature macro: LOGIC_OPERATION_SELECT_EN (adds OPERATION port).
module vector_xor_controller
  import vector_logic_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEFAULT,
  parameter int CONTROL_SIZE = CONTROL_SIZE_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
`ifdef LOGIC_OPERATION_SELECT_EN
  ,
  input  logic [1:0]              OPERATION
`endif
);

  state_t                  state_r;
  logic [CONTROL_SIZE-1:0] index_r;
  logic [CONTROL_SIZE-1:0] size_r;
  logic [DATA_SIZE-1:0]    data_out_r;
  logic                    ready_r;
  logic                    data_enable_r;
  logic                    data_out_enable_r;
  logic                    capture_en_s;
  logic                    clear_s;
  logic                    both_captured_s;
  logic [DATA_SIZE-1:0]    operand_a_s;
  logic [DATA_SIZE-1:0]    operand_b_s;
  logic [DATA_SIZE-1:0]    result_s;
  logic                    last_element_s;
`ifdef LOGIC_OPERATION_SELECT_EN
  logic_op_t               operation_r;
`endif

  assign capture_en_s = (state_r == STATE_INPUT);
  assign clear_s      = (state_r == STATE_COMPUTE);

  logic_operand_capture #(
    .DATA_SIZE (DATA_SIZE)
  ) u_operand_capture (
    .CLK              (CLK),
    .RST              (RST),
    .capture_en       (capture_en_s),
    .clear            (clear_s),
    .data_a_in_enable (DATA_A_IN_ENABLE),
    .data_b_in_enable (DATA_B_IN_ENABLE),
    .data_a_in        (DATA_A_IN),
    .data_b_in        (DATA_B_IN),
    .operand_a        (operand_a_s),
    .operand_b        (operand_b_s),
    .both_captured    (both_captured_s)
  );

  // Shared logic datapath
  always_comb begin
`ifdef LOGIC_OPERATION_SELECT_EN
    case (operation_r)
      OP_AND:  result_s = operand_a_s & operand_b_s;
      OP_OR:   result_s = operand_a_s | operand_b_s;
      OP_XOR:  result_s = operand_a_s ^ operand_b_s;
      OP_XNOR: result_s = ~(operand_a_s ^ operand_b_s);
      default: result_s = operand_a_s ^ operand_b_s;
    endcase
`else
    result_s = operand_a_s ^ operand_b_s;
`endif
  end

  // Compare against size-1 so the largest count finishes without index wrap
  assign last_element_s = (index_r == (size_r - ONE_CONTROL));

  // Sequencer, index counter and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r           <= STATE_IDLE;
      index_r           <= ZERO_CONTROL;
      size_r            <= ZERO_CONTROL;
      data_out_r        <= ZERO_DATA;
      ready_r           <= 1'b0;
      data_enable_r     <= 1'b0;
      data_out_enable_r <= 1'b0;
`ifdef LOGIC_OPERATION_SELECT_EN
      operation_r       <= OP_AND;
`endif
    end else begin
      ready_r           <= 1'b0;
      data_enable_r     <= 1'b0;
      data_out_enable_r <= 1'b0;
      case (state_r)
        STATE_IDLE: begin
          if (START) begin
            size_r  <= SIZE_IN;
            index_r <= ZERO_CONTROL;
`ifdef LOGIC_OPERATION_SELECT_EN
            operation_r <= logic_op_t'(OPERATION);
`endif
            if (SIZE_IN == ZERO_CONTROL) begin
              ready_r <= 1'b1;
            end else begin
              data_enable_r <= 1'b1;
              state_r       <= STATE_INPUT;
            end
          end
        end
        STATE_INPUT: begin
          if (both_captured_s) begin
            state_r <= STATE_COMPUTE;
          end
        end
        STATE_COMPUTE: begin
          data_out_r        <= result_s;
          data_out_enable_r <= 1'b1;
          if (last_element_s) begin
            ready_r <= 1'b1;
            state_r <= STATE_IDLE;
          end else begin
            index_r       <= index_r + ONE_CONTROL;
            data_enable_r <= 1'b1;
            state_r       <= STATE_INPUT;
          end
        end
        default: begin
          state_r <= STATE_IDLE;
        end
      endcase
    end
  end

  assign READY           = ready_r;
  assign DATA_ENABLE     = data_enable_r;
  assign DATA_OUT_ENABLE = data_out_enable_r;
  assign DATA_OUT        = data_out_r;

endmodule

// File: tb/tb_vector_xor_controller.sv
// Directed self-checking bench for vector_xor_controller.
module tb_vector_xor_controller;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_IN;
  logic        DATA_A_IN_ENABLE;
  logic        DATA_B_IN_ENABLE;
  logic [63:0] DATA_A_IN;
  logic [63:0] DATA_B_IN;
  logic        DATA_ENABLE;
  logic        DATA_OUT_ENABLE;
  logic [63:0] DATA_OUT;
`ifdef LOGIC_OPERATION_SELECT_EN
  logic [1:0]  OPERATION;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  vector_xor_controller #(
    .DATA_SIZE    (64),
    .CONTROL_SIZE (64)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .READY            (READY),
    .SIZE_IN          (SIZE_IN),
    .DATA_A_IN_ENABLE (DATA_A_IN_ENABLE),
    .DATA_B_IN_ENABLE (DATA_B_IN_ENABLE),
    .DATA_A_IN        (DATA_A_IN),
    .DATA_B_IN        (DATA_B_IN),
    .DATA_ENABLE      (DATA_ENABLE),
    .DATA_OUT_ENABLE  (DATA_OUT_ENABLE),
    .DATA_OUT         (DATA_OUT)
`ifdef LOGIC_OPERATION_SELECT_EN
    ,
    .OPERATION        (OPERATION)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_vector(input logic [63:0] size);
    SIZE_IN = size;
    START   = 1'b1;
    tick();
    START   = 1'b0;
  endtask

  // Expects DATA_ENABLE high now; supplies both operands in this cycle.
  task automatic step_pair(input string tag, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp,
                           input logic last);
    check_value({tag, "_de"}, 64'(DATA_ENABLE), 64'd1);
    DATA_A_IN = a;
    DATA_B_IN = b;
    DATA_A_IN_ENABLE = 1'b1;
    DATA_B_IN_ENABLE = 1'b1;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    START = 1'b0;
    check_value({tag, "_compute_doe"}, 64'(DATA_OUT_ENABLE), 64'd0);
    check_value({tag, "_compute_de"}, 64'(DATA_ENABLE), 64'd0);
    tick();
    check_value({tag, "_doe"}, 64'(DATA_OUT_ENABLE), 64'd1);
    check_value({tag, "_result"}, DATA_OUT, exp);
    check_value({tag, "_ready"}, 64'(READY), 64'(last));
    check_value({tag, "_next_de"}, 64'(DATA_ENABLE), 64'(!last));
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    SIZE_IN = 64'd0;
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    DATA_A_IN = 64'd0;
    DATA_B_IN = 64'd0;
`ifdef LOGIC_OPERATION_SELECT_EN
    OPERATION = 2'b10;
`endif
    tick();
    tick();
    check_value("rst_ready", 64'(READY), 64'd0);
    check_value("rst_de", 64'(DATA_ENABLE), 64'd0);
    check_value("rst_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    check_value("rst_dout", DATA_OUT, 64'd0);
    RST = 1'b0;
    tick();

    // Three elements back to back at full rate
    start_vector(64'd3);
    step_pair("v3e0", 64'hF0, 64'h0F, 64'hFF, 1'b0);
    step_pair("v3e1", 64'hFF, 64'hFF, 64'h00, 1'b0);
    step_pair("v3e2", 64'h00, 64'h55, 64'h55, 1'b1);

    // START accepted in the READY cycle, zero-length vector
    SIZE_IN = 64'd0;
    START = 1'b1;
    tick();
    START = 1'b0;
    check_value("size0_ready", 64'(READY), 64'd1);
    check_value("size0_de", 64'(DATA_ENABLE), 64'd0);
    check_value("size0_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    check_value("size0_hold", DATA_OUT, 64'h55);
    tick();
    check_value("size0_ready_drop", 64'(READY), 64'd0);
    check_value("size0_no_de", 64'(DATA_ENABLE), 64'd0);

    // B early, duplicate B ignored, A three cycles later
    start_vector(64'd2);
    check_value("ooo_de", 64'(DATA_ENABLE), 64'd1);
    DATA_B_IN = 64'h33;
    DATA_B_IN_ENABLE = 1'b1;
    tick();
    DATA_B_IN = 64'hAA;
    tick();
    DATA_B_IN_ENABLE = 1'b0;
    check_value("ooo_wait_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    tick();
    DATA_A_IN = 64'h5A;
    DATA_A_IN_ENABLE = 1'b1;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    check_value("ooo_compute_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    tick();
    check_value("ooo_doe", 64'(DATA_OUT_ENABLE), 64'd1);
    check_value("ooo_result", DATA_OUT, 64'h69);
    check_value("ooo_ready", 64'(READY), 64'd0);
    step_pair("ooo_e1", 64'h01, 64'h02, 64'h03, 1'b1);

    // Reset mid-vector after the second result
    start_vector(64'd4);
    step_pair("rst_e0", 64'h11, 64'h22, 64'h33, 1'b0);
    step_pair("rst_e1", 64'h44, 64'h88, 64'hCC, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check_value("abort_de", 64'(DATA_ENABLE), 64'd0);
    check_value("abort_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    check_value("abort_dout", DATA_OUT, 64'd0);
    check_value("abort_ready", 64'(READY), 64'd0);
    DATA_A_IN_ENABLE = 1'b1;
    DATA_B_IN_ENABLE = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    check_value("post_rst_ready", 64'(READY), 64'd0);
    check_value("post_rst_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    tick();
    check_value("post_rst_idle_de", 64'(DATA_ENABLE), 64'd0);
    start_vector(64'd1);
    step_pair("one_e0", 64'h12, 64'h34, 64'h26, 1'b1);

    // START during INPUT is ignored
    tick();
    start_vector(64'd2);
    SIZE_IN = 64'd9;
    START = 1'b1;
    step_pair("ign_e0", 64'hA0, 64'h0B, 64'hAB, 1'b0);
    step_pair("ign_e1", 64'hFF, 64'h0F, 64'hF0, 1'b1);
    tick();
    check_value("ign_no_ready", 64'(READY), 64'd0);
    check_value("ign_no_de", 64'(DATA_ENABLE), 64'd0);
    tick();
    check_value("ign_no_doe", 64'(DATA_OUT_ENABLE), 64'd0);

`ifdef LOGIC_OPERATION_SELECT_EN
    // Latched AND survives an OPERATION change mid-vector
    OPERATION = 2'b00;
    start_vector(64'd2);
    OPERATION = 2'b01;
    step_pair("op_e0", 64'hC3, 64'h0F, 64'h03, 1'b0);
    step_pair("op_e1", 64'hC3, 64'h0F, 64'h03, 1'b1);
    start_vector(64'd1);
    step_pair("op_or", 64'hC3, 64'h0F, 64'hCF, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vector_xor_controller.md
# vector_xor_controller

Sequences element-wise XOR of two operand vectors through one shared logic datapath inside the NTM computing/information tree. After a START strobe it requests each element with a DATA_ENABLE pulse. It captures the A and B operands, which arrive independently under their own enable strobes, and emits one registered result per element. It pulses READY once the whole vector of SIZE_IN elements is done. It is the sequencing layer above the scalar logic gates and feeds vector-level NTM blocks.

## Interface
- DATA_SIZE, 64, element width in bits
- CONTROL_SIZE, 64, width of length and index fields
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request to begin a vector; sampled only in IDLE
- READY  out  1  one-cycle pulse when the vector is complete
- SIZE_IN  in  CONTROL_SIZE  element count; latched on accepted START
- DATA_A_IN_ENABLE  in  1  DATA_A_IN valid this cycle
- DATA_B_IN_ENABLE  in  1  DATA_B_IN valid this cycle
- DATA_A_IN  in  DATA_SIZE  operand A element
- DATA_B_IN  in  DATA_SIZE  operand B element
- DATA_ENABLE  out  1  one-cycle pulse requesting the next element pair
- DATA_OUT_ENABLE  out  1  one-cycle pulse; DATA_OUT holds a new element result
- DATA_OUT  out  DATA_SIZE  registered result element
- OPERATION  in  2  operation select; present only with LOGIC_OPERATION_SELECT_EN

## Operation
- The block has one clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - READY, DATA_ENABLE and DATA_OUT_ENABLE = 0.
  - DATA_OUT = 0.
  - Index = 0, capture flags = 0, state = IDLE.
- States: IDLE, INPUT, COMPUTE.
- IDLE:
  - On START=1, latch SIZE_IN (and OPERATION when enabled) and clear the index.
  - If SIZE_IN=0: pulse READY next cycle and stay in IDLE. No DATA_ENABLE is issued.
  - Otherwise: pulse DATA_ENABLE next cycle and go to INPUT.
- INPUT:
  - DATA_A_IN_ENABLE captures DATA_A_IN and sets flag_a. DATA_B_IN_ENABLE captures DATA_B_IN and sets flag_b.
  - Operands may arrive in any order, in the same cycle, or any number of cycles apart.
  - An enable for an operand whose flag is already set is ignored; the first capture wins.
  - When both flags are set (including both set in the same cycle), go to COMPUTE.
- COMPUTE:
  - Register DATA_OUT = A ^ B, pulse DATA_OUT_ENABLE, clear both flags.
  - If index = size−1: pulse READY and go to IDLE.
  - Else: increment the index, pulse DATA_ENABLE and go to INPUT.
- START outside IDLE is ignored; SIZE_IN and OPERATION are not re-latched.
- Enables seen in IDLE or COMPUTE are ignored; no operand capture happens in those states.
- DATA_OUT holds its last value between DATA_OUT_ENABLE pulses.
- The index is CONTROL_SIZE bits wide and compared against the latched size. The maximum size 2^CONTROL_SIZE−1 completes without wrap-around.
- RST asserted mid-vector:
  - The vector is aborted, all state returns to reset values, and no READY is issued.
  - Operation resumes only on a new START after RST deasserts.

## Timing
- START sampled in cycle t → DATA_ENABLE high in cycle t+1, or READY high in t+1 if SIZE_IN=0.
- Last operand enable in cycle t → COMPUTE in t+1 → DATA_OUT and DATA_OUT_ENABLE valid in t+2.
- On the last element, READY and DATA_OUT_ENABLE are asserted in the same cycle.
- On every other element, the next DATA_ENABLE coincides with DATA_OUT_ENABLE.
- Minimum per-element throughput is 2 cycles, when both operands arrive in the cycle after DATA_ENABLE.
- A new START is accepted in the cycle READY is high (the block is already back in IDLE).

## Configuration
- Macro: LOGIC_OPERATION_SELECT_EN.
- Defined:
  - The OPERATION port exists and is latched on START.
  - Encoding: 00 = AND, 01 = OR, 10 = XOR, 11 = XNOR.
  - COMPUTE applies the latched operation.
- Undefined: the port is absent and COMPUTE always performs XOR.

## Structure
- Shared package (e.g. vector_logic_pkg) holds:
  - the state enum (IDLE, INPUT, COMPUTE);
  - the OPERATION encodings;
  - the ZERO_DATA, ZERO_CONTROL and ONE_CONTROL constants.
- One natural sub-module: logic_operand_capture, containing the A/B holding registers, first-wins flags, both-captured output and clear input.
- The FSM, index counter and result register stay in the top module.

## Test plan
- SIZE_IN=3, A={0xF0,0xFF,0x00}, B={0x0F,0xFF,0x55}, both operands in the cycle after each DATA_ENABLE:
  - outputs 0xFF, 0x00, 0x55 on three DATA_OUT_ENABLE pulses, two cycles apart;
  - READY coincides with the third pulse.
- SIZE_IN=2, B arrives 3 cycles before A, then a second B enable (0xAA) before A:
  - the second B enable is ignored;
  - result = A ^ first B, two cycles after the A enable.
- SIZE_IN=0, START pulse → READY one cycle later; no DATA_ENABLE and no DATA_OUT_ENABLE.
- SIZE_IN=4, RST asserted after the second result:
  - all outputs drop to 0 asynchronously and no READY is issued;
  - a new START with SIZE_IN=1 then completes normally.
- START pulsed while in INPUT with SIZE_IN=9, during a SIZE_IN=2 vector → ignored; exactly 2 results then READY.
- With LOGIC_OPERATION_SELECT_EN defined, OPERATION=00, A=0xC3, B=0x0F:
  - result 0x03;
  - OPERATION changed mid-vector has no effect until the next START.
